// File: rtl/shift_register_param.sv
// Parametrised serializer: loads a WIDTH-bit word and shifts out a programmable
// number of bits, one per enable strobe, with selectable direction and fill mode.
module shift_register_param #(
    parameter int WIDTH = 12,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             loadn,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    input  logic             enable,
    output logic             out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] remaining
);

    localparam logic StIdle  = 1'b0;
    localparam logic StShift = 1'b1;

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(WIDTH);

    logic             state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             fill;
    logic [WIDTH-1:0] shifted;

    // Rotate takes the bit leaving the register; replicate keeps the trailing edge bit.
    always_comb begin
        fill = 1'b0;
        unique case (mode_q)
            2'b00: fill = 1'b0;
            2'b01: fill = serial_in;
            2'b10: fill = dir_q ? q_q[WIDTH-1] : q_q[0];
            2'b11: fill = dir_q ? q_q[0] : q_q[WIDTH-1];
        endcase
        if (dir_q) begin
            shifted = {q_q[WIDTH-2:0], fill};
        end else begin
            shifted = {fill, q_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (!loadn) begin
            q_d     = data;
            dir_d   = dir;
            mode_d  = mode;
            rem_d   = (len > MaxLen) ? MaxLen : len;
            state_d = (len == '0) ? StIdle : StShift;
        end else if (state_q == StShift && enable && rem_q != '0) begin
            q_d   = shifted;
            rem_d = rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            q_q     <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign out       = dir_q ? q_q[WIDTH-1] : q_q[0];
    assign q         = q_q;
    assign busy      = (state_q == StShift);
    assign done      = done_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_shift_register_param.sv
// Bench for shift_register_param: directed frames checked against a behavioural
// frame model every cycle, plus literal expectations from hand-worked vectors.
module tb_shift_register_param;

    localparam int WIDTH = 12;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             resetn, loadn, dir, serial_in, enable;
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] len;
    logic [1:0]       mode;
    logic             out, busy, done;
    logic [WIDTH-1:0] q;
    logic [LEN_W-1:0] remaining;

    int n_checks = 0;
    int n_pass   = 0;

    shift_register_param #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn), .loadn(loadn), .data(data), .len(len), .dir(dir),
        .mode(mode), .serial_in(serial_in), .enable(enable), .out(out), .q(q),
        .busy(busy), .done(done), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Frame model: the word is shifted by plain arithmetic per the fill rules.
    logic [WIDTH-1:0] m_q;
    int               m_rem;
    logic             m_dir, m_busy, m_done;
    logic [1:0]       m_mode;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q = '0; m_rem = 0; m_dir = 0; m_mode = 0; m_busy = 0; m_done = 0;
        end else if (!loadn) begin
            m_q = data; m_dir = dir; m_mode = mode; m_done = 0;
            m_rem = (int'(len) > WIDTH) ? WIDTH : int'(len);
            m_busy = (len != 0);
        end else if (m_busy && enable) begin
            int unsigned w;
            w = m_q;
            if (!m_dir) begin
                case (m_mode)
                    2'd0: w = w / 2;
                    2'd1: w = w / 2 + (serial_in ? (1 << (WIDTH - 1)) : 0);
                    2'd2: w = w / 2 + (w % 2) * (1 << (WIDTH - 1));
                    default: w = w / 2 + (w >= (1 << (WIDTH - 1)) ? (1 << (WIDTH - 1)) : 0);
                endcase
            end else begin
                case (m_mode)
                    2'd0: w = w * 2;
                    2'd1: w = w * 2 + (serial_in ? 1 : 0);
                    2'd2: w = w * 2 + (w >= (1 << (WIDTH - 1)) ? 1 : 0);
                    default: w = w * 2 + (w % 2);
                endcase
                w = w % (1 << WIDTH);
            end
            m_q = WIDTH'(w);
            m_rem = m_rem - 1;
            m_done = (m_rem == 0);
            if (m_rem == 0) m_busy = 0;
        end else begin
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        chk("model_q", 32'(q), 32'(m_q));
        chk("model_out", 32'(out), 32'(m_dir ? m_q[WIDTH-1] : m_q[0]));
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_rem", 32'(remaining), 32'(m_rem));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l,
                        input logic dr, input logic [1:0] md);
        loadn = 0; data = d; len = l; dir = dr; mode = md;
        cyc();
        loadn = 1;
    endtask

    logic             exp1 [12] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    logic [WIDTH-1:0] exp2q [4] = '{12'h003, 12'h006, 12'h00C, 12'h018};
    logic             exp2o [4] = '{1, 0, 0, 0};
    logic [WIDTH-1:0] exp3q [3] = '{12'hC00, 12'hE00, 12'hF00};

    initial begin
        resetn = 0; loadn = 1; enable = 0; data = '0; len = '0; dir = 0; mode = 0;
        serial_in = 0;
        #1;
        chk("reset_q", 32'(q), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_rem", 32'(remaining), 0);
        #12 resetn = 1;
        cyc();

        // LSB-first zero fill, full width
        load(12'hA5C, 4'd12, 0, 2'b00);
        enable = 1;
        for (int i = 0; i < 12; i++) begin
            chk("t1_out", 32'(out), 32'(exp1[i]));
            chk("t1_nodone", 32'(done), 0);
            cyc();
        end
        chk("t1_done", 32'(done), 1);
        chk("t1_q", 32'(q), 0);
        chk("t1_busy", 32'(busy), 0);
        enable = 0;
        cyc();
        chk("t1_done_clr", 32'(done), 0);

        // MSB-first rotate
        load(12'h801, 4'd4, 1, 2'b10);
        chk("t2_rem0", 32'(remaining), 4);
        enable = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_out", 32'(out), 32'(exp2o[i]));
            cyc();
            chk("t2_q", 32'(q), 32'(exp2q[i]));
            chk("t2_rem", 32'(remaining), 32'(3 - i));
            chk("t2_done", 32'(done), (i == 3) ? 1 : 0);
        end
        enable = 0;
        cyc();
        chk("t2_done_clr", 32'(done), 0);

        // Replicate edge bit with enable gaps
        load(12'h800, 4'd3, 0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            enable = 1;
            cyc();
            enable = 0;
            chk("t3_q", 32'(q), 32'(exp3q[i]));
            if (i < 2) begin
                cyc();
                cyc();
                chk("t3_busy_gap", 32'(busy), 1);
                chk("t3_nodone", 32'(done), 0);
            end else begin
                chk("t3_done", 32'(done), 1);
            end
        end
        cyc();

        // Length clamp, zero length, enable while idle
        load(12'h123, 4'd15, 0, 2'b00);
        chk("t4_clamp", 32'(remaining), 12);
        chk("t4_busy", 32'(busy), 1);
        load(12'h5A5, 4'd0, 0, 2'b00);
        chk("t4_len0_busy", 32'(busy), 0);
        chk("t4_len0_done", 32'(done), 0);
        chk("t4_len0_q", 32'(q), 32'h5A5);
        enable = 1;
        cyc();
        cyc();
        chk("t4_idle_q", 32'(q), 32'h5A5);
        chk("t4_idle_rem", 32'(remaining), 0);
        enable = 0;

        // Abort by reload (load wins over enable), then async reset mid-frame
        load(12'hFFF, 4'd8, 0, 2'b00);
        enable = 1;
        cyc(); cyc(); cyc();
        enable = 0;
        chk("t5_rem5", 32'(remaining), 5);
        chk("t5_q", 32'(q), 32'h1FF);
        enable = 1;
        load(12'h3C3, 4'd6, 1, 2'b00);
        chk("t5_reload_q", 32'(q), 32'h3C3);
        chk("t5_reload_rem", 32'(remaining), 6);
        chk("t5_reload_done", 32'(done), 0);
        cyc();
        chk("t5_shift1", 32'(q), 32'h786);
        cyc();
        chk("t5_shift2", 32'(q), 32'hF0C);
        #1 resetn = 0;
        #1;
        chk("t5_rst_q", 32'(q), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_rem", 32'(remaining), 0);
        enable = 0;
        cyc();
        resetn = 1;
        cyc();

        // Serial-in fill
        load(12'h000, 4'd3, 0, 2'b01);
        enable = 1;
        serial_in = 1; cyc();
        chk("t6_q0", 32'(q), 32'h800);
        serial_in = 0; cyc();
        chk("t6_q1", 32'(q), 32'h400);
        serial_in = 1; cyc();
        chk("t6_q2", 32'(q), 32'hA00);
        chk("t6_done", 32'(done), 1);
        enable = 0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
